// File: rtl/i2c_config_sequencer_if.sv
// Bundle between the config sequencer, its register table and the I2C write engine.
// master: the sequencer side; slave: the table, the engine and the top-level status consumer.
// Signal names follow the HDMI top level they connect to.
interface i2c_config_sequencer_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic [IDX_W-1:0] tableIndex;
  logic [23:0]      tableData;
  logic [23:0]      i2cData;
  logic             i2cGo;
  logic             i2cComplete;
  logic             busy;
  logic             configDone;
  logic             configError;
  logic [IDX_W-1:0] errorIndex;

  modport master (
    input  start, tableData, i2cComplete,
    output tableIndex, i2cData, i2cGo, busy, configDone, configError, errorIndex
  );

  modport slave (
    output start, tableData, i2cComplete,
    input  tableIndex, i2cData, i2cGo, busy, configDone, configError, errorIndex
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a register table through the I2C write engine after power-up or on start.
// Go asserts 2 cycles after start; each entry costs engine time + 3 + GAP_CYCLES + 2.
// Engine backpressure is the go/complete handshake, guarded by a timeout with bounded retries.
module i2c_config_sequencer #(
  parameter int NUM_ENTRIES    = 31,
  parameter int IDX_W          = 5,
  parameter int STARTUP_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 24
) (
  input logic                   refClock,
  input logic                   reset,
  i2c_config_sequencer_if.master bus
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [RTY_W-1:0] RETRY_LAST   = RTY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_STARTUP,
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RELEASE,
    S_RETRY,
    S_BACKOFF,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RTY_W-1:0] retry_q;
  logic [IDX_W-1:0] idx_q;
  logic [23:0]      data_q;
  logic             go_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [IDX_W-1:0] err_idx_q;
  logic             cs1_q;
  logic             cs2_q;
  logic             cs3_q;
  logic             c_rise;

  // Shared delay/timeout counter never wraps; it sticks at all-ones.
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign c_rise = cs2_q & ~cs3_q;

  // Complete comes from the slower engine domain: two-flop sync plus an edge-detect flop.
  always_ff @(posedge refClock) begin
    if (reset) begin
      cs1_q <= 1'b0;
      cs2_q <= 1'b0;
      cs3_q <= 1'b0;
    end else begin
      cs1_q <= bus.i2cComplete;
      cs2_q <= cs1_q;
      cs3_q <= cs2_q;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge refClock) begin
    if (reset) begin
      state_q   <= S_STARTUP;
      cnt_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      case (state_q)
        S_STARTUP: begin
          if (cnt_q == STARTUP_LAST) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            retry_q <= '0;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q   <= S_LOAD;
            idx_q     <= '0;
            retry_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
          end
        end
        S_LOAD: begin
          data_q  <= bus.tableData;
          cnt_q   <= '0;
          go_q    <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: begin
          // Only a fresh rising edge counts, so a complete level left over from an
          // earlier frame cannot finish this one.
          if (c_rise) begin
            go_q    <= 1'b0;
            state_q <= S_RELEASE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            go_q    <= 1'b0;
            state_q <= S_RETRY;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RELEASE: begin
          // Hold off until the engine has dropped complete, so it is idle before the next go.
          if (!cs2_q) begin
            cnt_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_RETRY: begin
          if (retry_q == RETRY_LAST) begin
            state_q <= S_ERROR;
          end else begin
            retry_q <= retry_q + 1'b1;
            cnt_q   <= '0;
            state_q <= S_BACKOFF;
          end
        end
        S_BACKOFF: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              retry_q <= '0;
              state_q <= S_LOAD;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          err_q     <= 1'b1;
          err_idx_q <= idx_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          go_q    <= 1'b0;
          state_q <= S_STARTUP;
        end
      endcase
    end
  end

  assign bus.tableIndex  = idx_q;
  assign bus.i2cData     = data_q;
  assign bus.i2cGo       = go_q;
  assign bus.busy        = busy_q;
  assign bus.configDone  = done_q;
  assign bus.configError = err_q;
  assign bus.errorIndex  = err_idx_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: table model, I2C engine model and a data scoreboard.
// Expected i2cData values are queued per scenario and popped at every engine frame start.
// Status flags, go latency and frame counts are compared at the end of each scenario.
module tb_i2c_config_sequencer;

  localparam int NE = 4;
  localparam int IW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  i2c_config_sequencer_if #(.IDX_W(IW)) bus ();

  i2c_config_sequencer #(
    .NUM_ENTRIES   (NE),
    .IDX_W         (IW),
    .STARTUP_CYCLES(10),
    .TIMEOUT_CYCLES(100),
    .GAP_CYCLES    (4),
    .MAX_RETRY     (2),
    .CNT_W         (24)
  ) dut (
    .refClock(clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] tbl(input logic [IW-1:0] i);
    logic [7:0] ix;
    ix = {3'b000, i};
    return {8'h72, 8'h10 + ix, 8'h5A ^ ix};
  endfunction

  assign bus.tableData = tbl(bus.tableIndex);

  // Engine configuration, written only by the stimulus process.
  int hold_cyc   = 5;
  int fail_entry = -1;
  int fail_max   = 0;
  int cfg_gen    = 0;

  // Engine state, written only by the engine process.
  int          frames = 0;
  logic [23:0] exp_q[$];

  // Engine model: starts a frame whenever idle and go is high, raises complete
  // 20 cycles later for hold_cyc cycles; selected attempts on fail_entry hang.
  initial begin
    int          eng_st;
    int          eng_cnt;
    int          fail_used;
    int          seen_gen;
    logic        rst_seen;
    logic [23:0] frame_dat;
    eng_st    = 0;
    eng_cnt   = 0;
    fail_used = 0;
    seen_gen  = 0;
    rst_seen  = 1'b0;
    frame_dat = '0;
    bus.i2cComplete = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_gen != seen_gen) begin
        seen_gen  = cfg_gen;
        fail_used = 0;
      end
      if (reset) rst_seen = 1'b1;
      case (eng_st)
        0: if (bus.i2cGo === 1'b1) begin
          frames++;
          frame_dat = bus.i2cData;
          rst_seen  = 1'b0;
          if (exp_q.size() == 0) chk("sb_extra_frame", 32'd1, 32'd0);
          else chk("sb_data", {8'h00, bus.i2cData}, {8'h00, exp_q.pop_front()});
          if (int'(bus.tableIndex) == fail_entry && fail_used < fail_max) begin
            fail_used++;
            eng_st = 3;
          end else begin
            eng_cnt = 0;
            eng_st  = 1;
          end
        end
        1: begin
          eng_cnt++;
          if (eng_cnt == 20) begin
            if (!rst_seen) chk("data_stable", {8'h00, bus.i2cData}, {8'h00, frame_dat});
            bus.i2cComplete = 1'b1;
            eng_cnt = 0;
            eng_st  = 2;
          end
        end
        2: begin
          eng_cnt++;
          if (eng_cnt >= hold_cyc) begin
            bus.i2cComplete = 1'b0;
            eng_st = 0;
          end
        end
        default: if (bus.i2cGo !== 1'b1) eng_st = 0;
      endcase
    end
  end

  task automatic push_all();
    for (int i = 0; i < NE; i++) exp_q.push_back(tbl(IW'(i)));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic release_and_measure(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    reset = 1'b0;
    while (c < 200) begin
      @(posedge clk);
      #1;
      c++;
      if (bus.i2cGo === 1'b1) break;
    end
    chk(tag, c, 32'd11);
  endtask

  task automatic wait_flag(input string tag);
    int c;
    c = 0;
    while (!((bus.configDone || bus.configError) && !bus.busy) && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(c < 3000), 32'd1);
  endtask

  initial begin
    int f0;
    int c;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go",      bus.i2cGo,       0);
    chk("rst_busy",    bus.busy,        0);
    chk("rst_done",    bus.configDone,  0);
    chk("rst_err",     bus.configError, 0);
    chk("rst_erridx",  bus.errorIndex,  0);
    chk("rst_data",    bus.i2cData,     0);
    chk("rst_tblidx",  bus.tableIndex,  0);

    // Power-up pass with an ideal engine.
    push_all();
    f0 = frames;
    release_and_measure("s1_go_latency");
    chk("s1_busy_running", bus.busy, 1);
    wait_flag("s1_finish");
    chk("s1_done",   bus.configDone,  1);
    chk("s1_err",    bus.configError, 0);
    chk("s1_busy",   bus.busy,        0);
    chk("s1_frames", frames - f0,     4);
    chk("s1_sb_left", exp_q.size(),   0);

    // Long complete pulse must not double-trigger the engine.
    hold_cyc = 40;
    push_all();
    f0 = frames;
    pulse_start();
    chk("s2_clr_done", bus.configDone, 0);
    chk("s2_busy",     bus.busy,       1);
    wait_flag("s2_finish");
    chk("s2_done",   bus.configDone, 1);
    chk("s2_frames", frames - f0,    4);
    chk("s2_sb_left", exp_q.size(),  0);

    // Entry 2 never completes: three attempts, then error.
    hold_cyc   = 5;
    fail_entry = 2;
    fail_max   = 99;
    cfg_gen++;
    exp_q.push_back(tbl(5'd0));
    exp_q.push_back(tbl(5'd1));
    repeat (3) exp_q.push_back(tbl(5'd2));
    f0 = frames;
    pulse_start();
    wait_flag("s3_finish");
    chk("s3_err",    bus.configError, 1);
    chk("s3_erridx", bus.errorIndex,  2);
    chk("s3_done",   bus.configDone,  0);
    chk("s3_frames", frames - f0,     5);
    chk("s3_sb_left", exp_q.size(),   0);

    // Entry 1 times out once, then succeeds.
    fail_entry = 1;
    fail_max   = 1;
    cfg_gen++;
    exp_q.push_back(tbl(5'd0));
    exp_q.push_back(tbl(5'd1));
    exp_q.push_back(tbl(5'd1));
    exp_q.push_back(tbl(5'd2));
    exp_q.push_back(tbl(5'd3));
    f0 = frames;
    pulse_start();
    chk("s4_clr_err",    bus.configError, 0);
    chk("s4_clr_erridx", bus.errorIndex,  0);
    wait_flag("s4_finish");
    chk("s4_done",   bus.configDone,  1);
    chk("s4_err",    bus.configError, 0);
    chk("s4_frames", frames - f0,     5);
    chk("s4_sb_left", exp_q.size(),   0);

    // Second pass with a start pulse mid-pass that must be ignored.
    fail_entry = -1;
    fail_max   = 0;
    cfg_gen++;
    push_all();
    f0 = frames;
    pulse_start();
    repeat (60) @(negedge clk);
    chk("s5_busy_mid", bus.busy, 1);
    pulse_start();
    wait_flag("s5_finish");
    chk("s5_done", bus.configDone, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("s5_idle_after", bus.busy,  0);
    chk("s5_frames",     frames - f0, 4);
    chk("s5_sb_left",    exp_q.size(), 0);

    // Reset while entry 2 is in its request window.
    for (int i = 0; i < 3; i++) exp_q.push_back(tbl(IW'(i)));
    f0 = frames;
    pulse_start();
    c = 0;
    while (frames - f0 < 3 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("s6_reached_e2", 32'(c < 2000), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_go_drop",  bus.i2cGo,      0);
    chk("s6_busy",     bus.busy,       0);
    chk("s6_tblidx",   bus.tableIndex, 0);
    repeat (40) @(posedge clk);
    chk("s6_sb_pre", exp_q.size(), 0);
    push_all();
    f0 = frames;
    release_and_measure("s6_go_latency");
    wait_flag("s6_finish");
    chk("s6_done",    bus.configDone, 1);
    chk("s6_frames",  frames - f0,    4);
    chk("s6_sb_left", exp_q.size(),   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
